// File: rtl/dbg_bridge_pkg.sv
// Shared definitions for the host-to-bus debug bridge: opcodes, response codes
// and FSM state encoding.
package dbg_bridge_pkg;

    localparam logic [7:0] OP_WRITE    = 8'h01;
    localparam logic [7:0] OP_READ     = 8'h02;

    localparam logic [7:0] RSP_WR_OK   = 8'hA5;
    localparam logic [7:0] RSP_BAD_OP  = 8'hEE;
    localparam logic [7:0] RSP_TIMEOUT = 8'hEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RESP
    } state_t;

    function automatic logic is_valid_op(input logic [7:0] op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/dbg_bridge.sv
// Byte-stream debug bridge: decodes WRITE/READ commands from the host link,
// runs one word access on the bus with a timeout, and returns a response.
module dbg_bridge
    import dbg_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [21:0] bus_addr,
    output logic [31:0] bus_dout,
    input  logic [31:0] bus_din,
    input  logic        bus_ack
);

    state_t      state, state_nxt;
    logic [1:0]  byte_cnt;
    logic [7:0]  to_cnt;
    logic [23:0] addr_q;
    logic [31:0] data_q;
    logic        we_q;
    logic [31:0] resp_q;
    logic [1:0]  resp_left;
    logic        rx_fire, tx_fire, to_last;

    assign rx_fire = rx_valid & rx_ready;
    assign tx_fire = tx_valid & tx_ready;
    // Last permitted BUS cycle; an ack here still wins over the timeout.
    assign to_last = (to_cnt == 8'(TIMEOUT - 1));

    assign bus_we   = we_q;
    assign bus_addr = addr_q[23:2];
    assign bus_dout = data_q;
    assign tx_data  = resp_q[31:24];

    always_comb begin
        state_nxt = state;
        rx_ready  = 1'b0;
        tx_valid  = 1'b0;
        bus_stb   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                rx_ready = ~rst;
                if (rx_valid) state_nxt = is_valid_op(rx_data) ? ST_ADDR : ST_RESP;
            end
            ST_ADDR: begin
                rx_ready = ~rst;
                if (rx_valid && byte_cnt == 2'd2) state_nxt = we_q ? ST_DATA : ST_BUS;
            end
            ST_DATA: begin
                rx_ready = ~rst;
                if (rx_valid && byte_cnt == 2'd3) state_nxt = ST_BUS;
            end
            ST_BUS: begin
                bus_stb = 1'b1;
                if (bus_ack || to_last) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                tx_valid = 1'b1;
                if (tx_ready && resp_left == 2'd0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            byte_cnt  <= '0;
            to_cnt    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            resp_q    <= '0;
            resp_left <= '0;
        end else begin
            state  <= state_nxt;
            to_cnt <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (rx_fire) begin
                        byte_cnt <= '0;
                        we_q     <= (rx_data == OP_WRITE);
                        if (!is_valid_op(rx_data)) begin
                            resp_q    <= {RSP_BAD_OP, 24'h0};
                            resp_left <= '0;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_fire) begin
                        addr_q   <= {addr_q[15:0], rx_data};
                        byte_cnt <= (byte_cnt == 2'd2) ? 2'd0 : byte_cnt + 2'd1;
                    end
                end
                ST_DATA: begin
                    if (rx_fire) begin
                        data_q   <= {data_q[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                ST_BUS: begin
                    if (bus_ack) begin
                        resp_q    <= we_q ? {RSP_WR_OK, 24'h0} : bus_din;
                        resp_left <= we_q ? 2'd0 : 2'd3;
                    end else if (to_last) begin
                        resp_q    <= {RSP_TIMEOUT, 24'h0};
                        resp_left <= '0;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    // Response drains MSB first by shifting the next byte into [31:24].
                    if (tx_fire) begin
                        resp_q <= {resp_q[23:0], 8'h00};
                        if (resp_left != 2'd0) resp_left <= resp_left - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_bridge.sv
// Directed self-checking bench for dbg_bridge with hand-computed expectations.
module tb_dbg_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bus_stb;
    logic        bus_we;
    logic [21:0] bus_addr;
    logic [31:0] bus_dout;
    logic [31:0] bus_din;
    logic        bus_ack;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    dbg_bridge #(.TIMEOUT(255)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .bus_stb  (bus_stb),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_dout (bus_dout),
        .bus_din  (bus_din),
        .bus_ack  (bus_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned k;
        k = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && k < 100) begin
            tick();
            k++;
        end
        if (!rx_ready) check("rx_ready_wait", {31'h0, rx_ready}, 32'h1);
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] cmd [0:7], input int unsigned n, input int unsigned max_gap);
        for (int unsigned i = 0; i < n; i++) begin
            if (max_gap != 0) repeat ($urandom_range(max_gap, 0)) tick();
            send_byte(cmd[i]);
        end
    endtask

    // Responder: acks during the ack_at-th strobe cycle (0 = never); reports strobe length.
    task automatic run_bus(input int unsigned ack_at, input logic [31:0] din, output int unsigned n);
        logic [21:0] a0;
        logic [31:0] d0;
        logic        w0;
        logic        held;
        n    = 0;
        held = 1'b1;
        a0   = bus_addr;
        d0   = bus_dout;
        w0   = bus_we;
        bus_din = din;
        while (bus_stb && n < 400) begin
            n++;
            if (bus_addr !== a0 || bus_dout !== d0 || bus_we !== w0) held = 1'b0;
            if (n == ack_at) bus_ack = 1'b1;
            tick();
            bus_ack = 1'b0;
        end
        check("bus_fields_held", {31'h0, held}, 32'h1);
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] exp, input int unsigned stall);
        int unsigned k;
        k = 0;
        while (!tx_valid && k < 1000) begin
            tick();
            k++;
        end
        repeat (stall) tick();
        check({tag, "_valid"}, {31'h0, tx_valid}, 32'h1);
        check(tag, {24'h0, tx_data}, {24'h0, exp});
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    logic [7:0]  cmd [0:7];
    int unsigned n;
    logic        stable;

    initial begin
        rst      = 1'b1;
        rx_data  = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        bus_din  = '0;
        bus_ack  = 1'b0;

        // Reset values while rst is high
        tick();
        tick();
        check("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
        check("rst_bus_stb",  {31'h0, bus_stb},  32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data",  {24'h0, tx_data},  32'h0);
        check("rst_bus_addr", {10'h0, bus_addr}, 32'h0);
        check("rst_bus_we",   {31'h0, bus_we},   32'h0);
        check("rst_bus_dout", bus_dout,          32'h0);
        rst = 1'b0;
        tick();
        check("post_rst_rx_ready", {31'h0, rx_ready}, 32'h1);

        // Ack outside BUS is ignored
        bus_ack = 1'b1;
        repeat (3) tick();
        bus_ack = 1'b0;
        check("idle_ack_stb",      {31'h0, bus_stb},  32'h0);
        check("idle_ack_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("idle_ack_rx_ready", {31'h0, rx_ready}, 32'h1);

        // WRITE 01 00 10 08 DE AD BE EF, ack in 3rd strobe cycle
        cmd = '{8'h01, 8'h00, 8'h10, 8'h08, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_cmd(cmd, 8, 0);
        check("wr_stb_latency", {31'h0, bus_stb},  32'h1);
        check("wr_rx_ready_bus", {31'h0, rx_ready}, 32'h0);
        check("wr_addr", {10'h0, bus_addr}, 32'h0000_0402);
        check("wr_we",   {31'h0, bus_we},   32'h1);
        check("wr_dout", bus_dout,          32'hDEAD_BEEF);
        run_bus(3, 32'h0, n);
        check("wr_stb_cycles", n, 32'd3);
        recv_byte("wr_resp", 8'hA5, 0);
        check("wr_single_byte", {31'h0, tx_valid}, 32'h0);

        // READ 02 FF E0 00, ack in 1st strobe cycle, stalls between bytes
        cmd = '{8'h02, 8'hFF, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_cmd(cmd, 4, 0);
        check("rd_stb_latency", {31'h0, bus_stb},  32'h1);
        check("rd_addr", {10'h0, bus_addr}, 32'h003F_F800);
        check("rd_we",   {31'h0, bus_we},   32'h0);
        run_bus(1, 32'h1234_5678, n);
        check("rd_stb_cycles", n, 32'd1);
        recv_byte("rd_b0", 8'h12, 2);
        recv_byte("rd_b1", 8'h34, 0);
        recv_byte("rd_b2", 8'h56, 1);
        recv_byte("rd_b3", 8'h78, 0);
        check("rd_done_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rd_done_rx_ready", {31'h0, rx_ready}, 32'h1);

        // READ with no ack: exactly TIMEOUT strobe cycles, then 0xEF
        cmd = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_cmd(cmd, 4, 0);
        run_bus(0, 32'h0, n);
        check("to_stb_cycles", n, 32'd255);
        recv_byte("to_resp", 8'hEF, 0);
        check("to_idle_rx_ready", {31'h0, rx_ready}, 32'h1);

        // Ack on the last allowed cycle is a success
        cmd = '{8'h02, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
        send_cmd(cmd, 4, 0);
        check("edge_addr", {10'h0, bus_addr}, 32'h0000_0004);
        run_bus(255, 32'hA1B2_C3D4, n);
        check("edge_stb_cycles", n, 32'd255);
        recv_byte("edge_b0", 8'hA1, 0);
        recv_byte("edge_b1", 8'hB2, 0);
        recv_byte("edge_b2", 8'hC3, 0);
        recv_byte("edge_b3", 8'hD4, 0);

        // Unknown opcode 0x7F with tx_ready held low for 10 cycles
        send_byte(8'h7F);
        check("bad_tx_valid", {31'h0, tx_valid}, 32'h1);
        check("bad_tx_data",  {24'h0, tx_data},  32'h0000_00EE);
        stable = 1'b1;
        for (int unsigned i = 0; i < 10; i++) begin
            tick();
            if (tx_data !== 8'hEE || tx_valid !== 1'b1 || bus_stb !== 1'b0) stable = 1'b0;
        end
        check("bad_stall_stable", {31'h0, stable}, 32'h1);
        recv_byte("bad_resp", 8'hEE, 0);
        check("bad_single_byte", {31'h0, tx_valid}, 32'h0);

        // Gapped WRITE must produce the same bus transaction as the gap-free one
        cmd = '{8'h01, 8'h00, 8'h10, 8'h08, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_cmd(cmd, 8, 3);
        check("gap_stb",  {31'h0, bus_stb},  32'h1);
        check("gap_addr", {10'h0, bus_addr}, 32'h0000_0402);
        check("gap_we",   {31'h0, bus_we},   32'h1);
        check("gap_dout", bus_dout,          32'hDEAD_BEEF);
        run_bus(3, 32'h0, n);
        check("gap_stb_cycles", n, 32'd3);
        recv_byte("gap_resp", 8'hA5, 0);

        // Reset in the middle of a bus cycle
        cmd = '{8'h02, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        send_cmd(cmd, 4, 0);
        tick();
        check("mid_rst_pre_stb", {31'h0, bus_stb}, 32'h1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_stb",      {31'h0, bus_stb},  32'h0);
        check("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("mid_rst_rx_ready", {31'h0, rx_ready}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("mid_rst_rx_after", {31'h0, rx_ready}, 32'h1);
        check("mid_rst_idle_stb", {31'h0, bus_stb},  32'h0);
        cmd = '{8'h02, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
        send_cmd(cmd, 4, 0);
        check("fresh_addr", {10'h0, bus_addr}, 32'h0000_0002);
        check("fresh_we",   {31'h0, bus_we},   32'h0);
        run_bus(2, 32'hCAFE_F00D, n);
        check("fresh_stb_cycles", n, 32'd2);
        recv_byte("fresh_b0", 8'hCA, 0);
        recv_byte("fresh_b1", 8'hFE, 0);
        recv_byte("fresh_b2", 8'hF0, 0);
        recv_byte("fresh_b3", 8'h0D, 0);
        check("fresh_done_tx_valid", {31'h0, tx_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
